// File: rtl/rom_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_arb_pkg
// Brief    : Shared types and constants for the ROM fetch arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rom_arb_pkg;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    // Never returns less than 1 so single-bit index ports stay legal.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return (result < 1) ? 1 : result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_fetch_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_fetch_arbiter_if
// Brief    : Requester-side and SDRAM-side signals of the ROM fetch arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface rom_fetch_arbiter_if
    import rom_arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    localparam int IDX_W = clog2(N);

    logic [N-1:0]        req;
    logic [N*ADDR_W-1:0] req_addr;
    logic [N-1:0]        req_valid;
    logic [DATA_W-1:0]   req_data;
    logic                rom_req;
    logic [ADDR_W-1:0]   rom_addr;
    logic [DATA_W-1:0]   rom_data;
    logic                rom_valid;
    logic                busy;
    logic [IDX_W-1:0]    grant_idx;

    // slave: the arbiter itself; master: caches plus SDRAM controller
    modport slave (
        input  req, req_addr, rom_data, rom_valid,
        output req_valid, req_data, rom_req, rom_addr, busy, grant_idx
    );

    modport master (
        output req, req_addr, rom_data, rom_valid,
        input  req_valid, req_data, rom_req, rom_addr, busy, grant_idx
    );

endinterface
`default_nettype wire

// File: rtl/rom_fetch_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first set request from ptr up.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] w_sel;

    // Walk from the farthest candidate back to ptr so the nearest hit wins.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        w_sel = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sel = IDX_W'((int'(ptr_i) + k) % N);
            if (req_i[w_sel]) begin
                any_o = 1'b1;
                idx_o = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_fetch_arbiter
// Brief    : Round-robin sharing of one SDRAM ROM read port, one transaction.
// Revision : 1.0 - initial release
// ============================================================================
module rom_fetch_arbiter
    import rom_arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    rom_fetch_arbiter_if.slave  bus
);

    localparam int IDX_W = clog2(N);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_WAIT = 2'(WAIT);
    localparam logic [1:0] ST_GAP  = 2'(GAP);

    logic [1:0]        state_q,   state_d;
    logic [IDX_W-1:0]  ptr_q,     ptr_d;
    logic [IDX_W-1:0]  grant_q,   grant_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              rom_req_q, rom_req_d;
    logic [N-1:0]      valid_q,   valid_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              busy_q;

    logic              w_pick_any;
    logic [IDX_W-1:0]  w_pick_idx;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .any_o (w_pick_any),
        .idx_o (w_pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        rom_req_d = rom_req_q;
        valid_d   = '0;
        data_d    = data_q;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_any) begin
                    grant_d   = w_pick_idx;
                    addr_d    = bus.req_addr[int'(w_pick_idx) * ADDR_W +: ADDR_W];
                    rom_req_d = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // SDRAM cannot cancel, so a withdrawn request still completes
                // here; only the delivery pulse is suppressed.
                if (bus.rom_valid) begin
                    data_d = bus.rom_data;
                    if (bus.req[grant_q]) begin
                        valid_d[grant_q] = 1'b1;
                    end
                    rom_req_d = 1'b0;
                    ptr_d     = (int'(grant_q) == N - 1) ? '0 : grant_q + 1'b1;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                // Requester drops or changes req during this cycle.
                state_d = ST_IDLE;
            end
            default: begin
                rom_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            addr_q    <= '0;
            rom_req_q <= 1'b0;
            valid_q   <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            rom_req_q <= rom_req_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign bus.rom_req   = rom_req_q;
    assign bus.rom_addr  = addr_q;
    assign bus.req_valid = valid_q;
    assign bus.req_data  = data_q;
    assign bus.busy      = busy_q;
    assign bus.grant_idx = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_fetch_arbiter
// Brief    : Directed plus random bench for rom_fetch_arbiter with a
//            transaction-level reference model and an SDRAM responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_fetch_arbiter;
    import rom_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 20;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rom_fetch_arbiter_if #(.N(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    rom_fetch_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: transaction view of the arbiter
    int            m_ptr, m_grant;
    bit            m_active, m_gap;
    logic [AW-1:0] m_addr;
    logic [N-1:0]  m_valid;
    logic [DW-1:0] m_data;
    bit            ev_grant, ev_done;
    int            grants[$];
    logic [AW-1:0] gaddrs[$];

    // SDRAM responder
    bit auto_rom, rand_lat, spurious_en, r_busy;
    int fix_lat, r_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        logic [N-1:0] t;
        for (int k = 0; k < N; k++) begin
            t = r >> ((p + k) % N);
            if (t[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_grant = 0; m_active = 0; m_gap = 0;
        m_addr = '0; m_valid = '0; m_data = '0; r_busy = 0; r_cnt = 0;
    endtask

    task automatic cycle();
        logic [N-1:0]    p_req  = bus.req;
        logic [N*AW-1:0] p_addr = bus.req_addr;
        bit              p_rv   = bus.rom_valid;
        logic [DW-1:0]   p_rd   = bus.rom_data;
        bit              p_rst  = reset;
        int              g;
        logic [N-1:0]    t;
        @(posedge clk);
        #1;
        ev_grant = 0;
        ev_done  = 0;
        m_valid  = '0;
        if (p_rst) begin
            model_reset();
        end else if (m_gap) begin
            m_gap = 0;
        end else if (!m_active) begin
            g = pick(p_req, m_ptr);
            if (g >= 0) begin
                m_grant  = g;
                m_addr   = p_addr[g*AW +: AW];
                m_active = 1;
                ev_grant = 1;
                grants.push_back(int'(bus.grant_idx));
                gaddrs.push_back(bus.rom_addr);
            end
        end else if (p_rv) begin
            t = p_req >> m_grant;
            if (t[0]) m_valid = N'(1) << m_grant;
            m_data   = p_rd;
            m_active = 0;
            m_gap    = 1;
            m_ptr    = (m_grant + 1) % N;
            ev_done  = 1;
        end
        chk("rom_req",   bus.rom_req,   m_active);
        chk("busy",      bus.busy,      m_active | m_gap);
        chk("grant_idx", bus.grant_idx, m_grant);
        chk("rom_addr",  bus.rom_addr,  m_addr);
        chk("req_valid", bus.req_valid, m_valid);
        chk("req_data",  bus.req_data,  m_data);
        bus.rom_valid = 1'b0;
        if (auto_rom) begin
            if (bus.rom_req && !r_busy) begin
                r_busy = 1;
                r_cnt  = rand_lat ? int'($urandom_range(0, 4)) : fix_lat;
            end
            if (r_busy) begin
                if (r_cnt == 0) begin
                    bus.rom_valid = 1'b1;
                    bus.rom_data  = $urandom;
                    r_busy        = 0;
                end else begin
                    r_cnt--;
                end
            end else if (spurious_en && !bus.rom_req && $urandom_range(0, 7) == 0) begin
                bus.rom_valid = 1'b1;
                bus.rom_data  = $urandom;
            end
        end
    endtask

    task automatic wait_grant(input string tag, input int maxc);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            cycle();
            seen = ev_grant;
        end
        chk(tag, seen, 1);
    endtask

    task automatic wait_done(input string tag, input int maxc);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            cycle();
            seen = ev_done;
        end
        chk(tag, seen, 1);
    endtask

    initial begin
        reset = 1'b1;
        bus.req = '0; bus.req_addr = '0; bus.rom_valid = 1'b0; bus.rom_data = '0;
        auto_rom = 0; rand_lat = 0; spurious_en = 0; fix_lat = 2;
        model_reset();
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        // single requester, valid three cycles after rom_req
        auto_rom = 1; fix_lat = 2;
        bus.req_addr[0*AW +: AW] = 20'h12340;
        bus.req = 4'b0001;
        wait_done("single_done", 20);
        chk("single_addr",  gaddrs[$], 20'h12340);
        chk("single_valid", bus.req_valid, 4'b0001);
        bus.req = '0;
        cycle();
        chk("single_gap_req", bus.rom_req, 1'b0);
        cycle();
        chk("single_gap2_req", bus.rom_req, 1'b0);

        // all four held, four-cycle SDRAM latency
        reset = 1'b1; cycle(); reset = 1'b0;
        grants.delete();
        for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = AW'($urandom);
        fix_lat = 3;
        bus.req = 4'b1111;
        repeat (5) wait_done("rr_done", 40);
        bus.req = '0;
        chk("rr_count", grants.size(), 5);
        for (int i = 0; i < 5; i++) chk("rr_order", grants[i], i % N);

        // pointer fairness: req[2] held, req[1] raised while 2 is served
        bus.req = 4'b0100;
        wait_grant("fair_g2", 10);
        chk("fair_first", grants[$], 2);
        bus.req = 4'b0110;
        wait_done("fair_d2", 20);
        wait_grant("fair_g1", 10);
        chk("fair_next", grants[$], 1);
        wait_done("fair_d1", 20);
        bus.req = '0;

        // withdraw during WAIT
        bus.req = 4'b1000;
        wait_grant("wd_grant", 10);
        chk("wd_idx", grants[$], 3);
        cycle();
        bus.req = '0;
        wait_done("wd_done", 20);
        chk("wd_no_valid", bus.req_valid, 4'b0000);
        bus.req = 4'b0001;
        wait_grant("wd_next_grant", 10);
        chk("wd_next_idx", grants[$], 0);
        wait_done("wd_next_done", 20);
        chk("wd_next_valid", bus.req_valid, 4'b0001);
        bus.req = '0;
        cycle();

        // reset while waiting on SDRAM, then a stale return
        bus.req = 4'b0010;
        wait_grant("rst_grant", 10);
        reset = 1'b1;
        cycle();
        chk("rst_rom_req", bus.rom_req, 1'b0);
        chk("rst_busy",    bus.busy,    1'b0);
        reset = 1'b0; bus.req = '0; auto_rom = 0;
        cycle();
        bus.rom_valid = 1'b1; bus.rom_data = 32'hCAFEF00D;
        cycle();
        chk("rst_stale_valid", bus.req_valid, 4'b0000);
        chk("rst_stale_data",  bus.req_data,  32'h0);

        // stale valid in IDLE with no request
        bus.rom_valid = 1'b1; bus.rom_data = 32'h0BADF00D;
        cycle();
        chk("idle_stale_valid", bus.req_valid, 4'b0000);
        chk("idle_stale_data",  bus.req_data,  32'h0);
        chk("idle_stale_busy",  bus.busy,      1'b0);

        // random traffic against the model
        auto_rom = 1; rand_lat = 1; spurious_en = 1;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) bus.req_addr[i*AW +: AW] = AW'($urandom);
            cycle();
        end
        bus.req = '0;
        repeat (12) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
